// File: rtl/serial_tx.sv
// 8N1 serialiser: one 8-bit word per trigger, LSB first, line idles high.
// Every output comes straight from a flop, so inputs never reach the pins combinationally.
module serial_tx #(
  parameter int DIVISOR = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       trigger,
  input  logic [7:0] data_in,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          shift_d = data_in;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            // Next bit is shift_q[1] because the shift lands in the same edge.
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
